// File: rtl/riscv_decode_stage_pkg.sv
// riscv_decode_stage_pkg
// Shared types for the RV32I decode stage: opcode and ALU-op encodings,
// immediate formats, the decoded micro-op (uop_t), and small helpers
// (immediate extraction, saturating counter add).
package riscv_decode_stage_pkg;

  localparam int DECODE_WIDTH_MAX = 4;

  typedef enum logic [6:0] {
    OPCODE_INVALID = 7'h00,
    OPCODE_LOAD    = 7'h03,
    OPCODE_OP_IMM  = 7'h13,
    OPCODE_AUIPC   = 7'h17,
    OPCODE_STORE   = 7'h23,
    OPCODE_OP      = 7'h33,
    OPCODE_LUI     = 7'h37,
    OPCODE_BRANCH  = 7'h63,
    OPCODE_JALR    = 7'h67,
    OPCODE_JAL     = 7'h6F
  } opcode_t;

  // Encoding is {funct7[5], funct3}.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SLL  = 4'h1,
    ALU_SLT  = 4'h2,
    ALU_SLTU = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SRL  = 4'h5,
    ALU_OR   = 4'h6,
    ALU_AND  = 4'h7,
    ALU_SUB  = 4'h8,
    ALU_SRA  = 4'hD
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_fmt_t;

  typedef struct packed {
    logic        valid;
    opcode_t     opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    alu_op_t     alu_op;
    logic [2:0]  branch_cond;
    logic [2:0]  mem_size;
    logic        is_immediate;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
  } uop_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {30'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/riscv_decode_stage_if.sv
// riscv_decode_stage_if
// Fetch-side and issue-side handshake buses of the decode stage.
//   in_*  : fetch bundle (valid/ready, DECODE_WIDTH instructions, lane mask, lane-0 PC)
//   out_* : decoded bundle (valid/ready, per-lane uop, PC and illegal flag)
// Modport master is the decode stage; slave is its environment.
interface riscv_decode_stage_if
  import riscv_decode_stage_pkg::*;
#(
  parameter int DECODE_WIDTH = 2,
  parameter int XLEN         = 32
);
  logic                           in_valid_i;
  logic                           in_ready_o;
  logic [32*DECODE_WIDTH-1:0]     in_instr_i;
  logic [DECODE_WIDTH-1:0]        in_mask_i;
  logic [XLEN-1:0]                in_pc_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  uop_t [DECODE_WIDTH-1:0]        out_uop_o;
  logic [XLEN*DECODE_WIDTH-1:0]   out_pc_o;
  logic [DECODE_WIDTH-1:0]        out_illegal_o;

  modport master (
    input  in_valid_i, in_instr_i, in_mask_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_uop_o, out_pc_o, out_illegal_o
  );

  modport slave (
    output in_valid_i, in_instr_i, in_mask_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_uop_o, out_pc_o, out_illegal_o
  );
endinterface

// File: rtl/riscv_decode_stage_lane.sv
// riscv_decode_stage_lane
// Combinational single-instruction RV32I decoder.
//   instr_i   : raw 32-bit instruction
//   present_i : lane carries an instruction (mask bit)
//   uop_o     : decoded micro-op (all zero when absent or illegal)
//   illegal_o : present lane whose opcode/funct3/funct7 is not RV32I
module riscv_decode_stage_lane
  import riscv_decode_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        present_i,
  output uop_t        uop_o,
  output logic        illegal_o
);
  logic [6:0] opc;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  imm_fmt_t   fmt;

  assign opc    = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    legal = 1'b0;
    fmt   = IMM_NONE;
    case (opc)
      OPCODE_LOAD:   begin legal = (funct3 != 3'b011) && (funct3 <= 3'b101); fmt = IMM_I; end
      OPCODE_STORE:  begin legal = (funct3 <= 3'b010); fmt = IMM_S; end
      OPCODE_BRANCH: begin legal = (funct3[2:1] != 2'b01); fmt = IMM_B; end
      OPCODE_JALR:   begin legal = (funct3 == 3'b000); fmt = IMM_I; end
      OPCODE_JAL:    begin legal = 1'b1; fmt = IMM_J; end
      OPCODE_LUI,
      OPCODE_AUIPC:  begin legal = 1'b1; fmt = IMM_U; end
      OPCODE_OP_IMM: begin
        fmt = IMM_I;
        // Shift-immediates reuse imm[11:5] as funct7.
        case (funct3)
          3'b001:  legal = (funct7 == 7'h00);
          3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: legal = 1'b1;
        endcase
      end
      OPCODE_OP: legal = (funct7 == 7'h00) ||
                         ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    uop_o     = '0;
    illegal_o = 1'b0;
    if (present_i && !legal) begin
      illegal_o = 1'b1;
    end else if (present_i) begin
      uop_o.valid        = 1'b1;
      uop_o.opcode       = opcode_t'(opc);
      uop_o.rd           = instr_i[11:7];
      uop_o.rs1          = instr_i[19:15];
      uop_o.rs2          = instr_i[24:20];
      uop_o.imm          = imm_gen(instr_i, fmt);
      uop_o.is_load      = (opc == OPCODE_LOAD);
      uop_o.is_store     = (opc == OPCODE_STORE);
      uop_o.is_branch    = (opc == OPCODE_BRANCH);
      uop_o.is_jump      = (opc == OPCODE_JAL) || (opc == OPCODE_JALR);
      uop_o.is_immediate = (opc != OPCODE_OP);
      uop_o.uses_rs1     = !((opc == OPCODE_LUI) || (opc == OPCODE_AUIPC) || (opc == OPCODE_JAL));
      uop_o.uses_rs2     = (opc == OPCODE_OP) || (opc == OPCODE_STORE) || (opc == OPCODE_BRANCH);
      uop_o.writes_rd    = !((opc == OPCODE_STORE) || (opc == OPCODE_BRANCH)) &&
                           (instr_i[11:7] != 5'd0);
      uop_o.branch_cond  = (opc == OPCODE_BRANCH) ? funct3 : 3'b000;
      uop_o.mem_size     = ((opc == OPCODE_LOAD) || (opc == OPCODE_STORE)) ? funct3 : 3'b000;
      if (opc == OPCODE_OP)
        uop_o.alu_op = alu_op_t'({funct7[5], funct3});
      else if (opc == OPCODE_OP_IMM)
        uop_o.alu_op = alu_op_t'({(funct3 == 3'b101) & funct7[5], funct3});
      else if (opc == OPCODE_BRANCH)
        uop_o.alu_op = ALU_SUB;
      else
        uop_o.alu_op = ALU_ADD;
    end
  end
endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage
// N-wide RV32I decode stage between fetch and issue. Each lane is decoded
// combinationally, then held in a main output register backed by a skid
// register so full throughput is kept under backpressure without a
// combinational ready path.
//   clk, rst (sync, active-high), flush_i (drop everything this cycle)
//   bus            : riscv_decode_stage_if.master (in_* fetch side, out_* issue side)
//   stat_uops_o    : saturating count of valid uops delivered   (RISCV_DECODE_STATS_EN)
//   stat_illegal_o : saturating count of illegal lanes delivered (RISCV_DECODE_STATS_EN)
// Optional feature macro: RISCV_DECODE_STATS_EN.
module riscv_decode_stage
  import riscv_decode_stage_pkg::*;
#(
  parameter int DECODE_WIDTH = 2,
  parameter int XLEN         = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  riscv_decode_stage_if.master       bus
`ifdef RISCV_DECODE_STATS_EN
  ,
  output logic [31:0]                stat_uops_o,
  output logic [31:0]                stat_illegal_o
`endif
);
  uop_t [DECODE_WIDTH-1:0]      dec_uop, main_uop_reg, main_uop_next, skid_uop_reg, skid_uop_next;
  logic [XLEN*DECODE_WIDTH-1:0] dec_pc, main_pc_reg, main_pc_next, skid_pc_reg, skid_pc_next;
  logic [DECODE_WIDTH-1:0]      dec_ill, main_ill_reg, main_ill_next, skid_ill_reg, skid_ill_next;
  logic                         main_valid_reg, main_valid_next, skid_valid_reg, skid_valid_next;
  logic                         accept, drain;

  generate
    for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_lane
      riscv_decode_stage_lane u_lane (
        .instr_i   (bus.in_instr_i[32*gi +: 32]),
        .present_i (bus.in_mask_i[gi]),
        .uop_o     (dec_uop[gi]),
        .illegal_o (dec_ill[gi])
      );
      // Wraps modulo 2^XLEN.
      assign dec_pc[XLEN*gi +: XLEN] = bus.in_pc_i + XLEN'(4 * gi);
    end
  endgenerate

  // Ready depends only on the skid flop, never on out_ready_i.
  assign accept = bus.in_valid_i && !skid_valid_reg;
  assign drain  = main_valid_reg && bus.out_ready_i;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_uop_next   = main_uop_reg;
    main_pc_next    = main_pc_reg;
    main_ill_next   = main_ill_reg;
    skid_valid_next = skid_valid_reg;
    skid_uop_next   = skid_uop_reg;
    skid_pc_next    = skid_pc_reg;
    skid_ill_next   = skid_ill_reg;
    if (flush_i) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (drain) begin
      if (skid_valid_reg) begin
        main_uop_next   = skid_uop_reg;
        main_pc_next    = skid_pc_reg;
        main_ill_next   = skid_ill_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_uop_next = dec_uop;
        main_pc_next  = dec_pc;
        main_ill_next = dec_ill;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_reg) begin
        skid_valid_next = 1'b1;
        skid_uop_next   = dec_uop;
        skid_pc_next    = dec_pc;
        skid_ill_next   = dec_ill;
      end else begin
        main_valid_next = 1'b1;
        main_uop_next   = dec_uop;
        main_pc_next    = dec_pc;
        main_ill_next   = dec_ill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_uop_reg   <= '0;
      main_pc_reg    <= '0;
      main_ill_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_uop_reg   <= '0;
      skid_pc_reg    <= '0;
      skid_ill_reg   <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_uop_reg   <= main_uop_next;
      main_pc_reg    <= main_pc_next;
      main_ill_reg   <= main_ill_next;
      skid_valid_reg <= skid_valid_next;
      skid_uop_reg   <= skid_uop_next;
      skid_pc_reg    <= skid_pc_next;
      skid_ill_reg   <= skid_ill_next;
    end
  end

  assign bus.in_ready_o    = !skid_valid_reg;
  assign bus.out_valid_o   = main_valid_reg;
  assign bus.out_uop_o     = main_uop_reg;
  assign bus.out_pc_o      = main_pc_reg;
  assign bus.out_illegal_o = main_ill_reg;

`ifdef RISCV_DECODE_STATS_EN
  logic [31:0] stat_uops_reg, stat_illegal_reg;
  logic [2:0]  n_uops, n_ill;

  always_comb begin
    n_uops = 3'd0;
    n_ill  = 3'd0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      n_uops = n_uops + 3'(main_uop_reg[j].valid);
      n_ill  = n_ill + 3'(main_ill_reg[j]);
    end
  end

  // A flushed bundle is not delivered even if the consumer was ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_uops_reg    <= '0;
      stat_illegal_reg <= '0;
    end else if (drain && !flush_i) begin
      stat_uops_reg    <= sat_add(stat_uops_reg, n_uops);
      stat_illegal_reg <= sat_add(stat_illegal_reg, n_ill);
    end
  end

  assign stat_uops_o    = stat_uops_reg;
  assign stat_illegal_o = stat_illegal_reg;
`endif
endmodule

// File: tb/tb_riscv_decode_stage.sv
module tb_riscv_decode_stage;
  import riscv_decode_stage_pkg::*;

  localparam int DW = 2;
  localparam int XL = 32;

  typedef struct packed {
    uop_t [DW-1:0]      uop;
    logic [XL*DW-1:0]   pc;
    logic [DW-1:0]      ill;
  } bundle_t;

  logic clk;
  logic rst;
  logic flush;
  riscv_decode_stage_if #(.DECODE_WIDTH(DW), .XLEN(XL)) bus ();
`ifdef RISCV_DECODE_STATS_EN
  logic [31:0] stat_uops, stat_illegal;
`endif

  riscv_decode_stage #(.DECODE_WIDTH(DW), .XLEN(XL)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus)
`ifdef RISCV_DECODE_STATS_EN
    ,
    .stat_uops_o    (stat_uops),
    .stat_illegal_o (stat_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bundle_t q[$];
  logic [31:0] m_uops, m_ill;
  logic [6:0]  op_tab [9];

  task automatic expect_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: ISA rules written out directly, immediates by arithmetic.
  function automatic void ref_decode(input logic [31:0] w, input logic present,
                                     output uop_t u, output logic ill);
    int f3, f7, op;
    int signed sw;
    bit ok;
    u   = '0;
    ill = 1'b0;
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    op  = int'(w[6:0]);
    sw  = int'(w);
    if (!present) return;
    case (op)
      'h03:               ok = (f3 inside {0, 1, 2, 4, 5});
      'h23:               ok = (f3 <= 2);
      'h63:               ok = !(f3 inside {2, 3});
      'h67:               ok = (f3 == 0);
      'h13:               ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
      'h33:               ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      'h37, 'h17, 'h6F:   ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    if (!ok) begin
      ill = 1'b1;
      return;
    end
    u.valid  = 1'b1;
    u.opcode = opcode_t'(w[6:0]);
    u.rd     = w[11:7];
    u.rs1    = w[19:15];
    u.rs2    = w[24:20];
    case (op)
      'h03, 'h13, 'h67: u.imm = 32'(sw >>> 20);
      'h23: u.imm = 32'((sw >>> 25) * 32 + int'(w[11:7]));
      'h63: u.imm = 32'((sw >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
      'h37, 'h17: u.imm = w & 32'hFFFF_F000;
      'h6F: u.imm = 32'((sw >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
      default: u.imm = 32'd0;
    endcase
    if (op == 'h33 || (op == 'h13 && f3 == 5)) u.alu_op = alu_op_t'(4'(f3 + (w[30] ? 8 : 0)));
    else if (op == 'h13) u.alu_op = alu_op_t'(4'(f3));
    else if (op == 'h63) u.alu_op = ALU_SUB;
    else u.alu_op = ALU_ADD;
    u.branch_cond  = (op == 'h63) ? 3'(f3) : 3'd0;
    u.mem_size     = (op == 'h03 || op == 'h23) ? 3'(f3) : 3'd0;
    u.is_immediate = (op != 'h33);
    u.uses_rs1     = !(op inside {'h37, 'h17, 'h6F});
    u.uses_rs2     = (op inside {'h33, 'h23, 'h63});
    u.writes_rd    = !(op inside {'h23, 'h63}) && (w[11:7] != 5'd0);
    u.is_load      = (op == 'h03);
    u.is_store     = (op == 'h23);
    u.is_branch    = (op == 'h63);
    u.is_jump      = (op == 'h6F || op == 'h67);
  endfunction

  function automatic bundle_t ref_bundle(input logic [32*DW-1:0] instr, input logic [DW-1:0] mask,
                                         input logic [XL-1:0] pc);
    bundle_t b;
    uop_t tu;
    logic ti;
    for (int j = 0; j < DW; j++) begin
      ref_decode(instr[32*j +: 32], mask[j], tu, ti);
      b.uop[j] = tu;
      b.ill[j] = ti;
      b.pc[XL*j +: XL] = pc + XL'(4 * j);
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = int'($urandom_range(0, 10));
    if (sel < 9) w[6:0] = op_tab[sel];
    if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  // Predict the coming edge from current inputs, advance one cycle, compare.
  task automatic cycle();
    int n;
    bit acc, drn;
    bundle_t nb;
    n   = q.size();
    drn = (n > 0) && bus.out_ready_i;
    acc = bus.in_valid_i && (n < 2);
    if (rst) begin
      q.delete();
      m_uops = 0;
      m_ill  = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      nb = ref_bundle(bus.in_instr_i, bus.in_mask_i, bus.in_pc_i);
      if (drn) begin
        for (int j = 0; j < DW; j++) begin
          m_uops = m_uops + 32'(q[0].uop[j].valid);
          m_ill  = m_ill + 32'(q[0].ill[j]);
        end
        void'(q.pop_front());
      end
      if (acc) q.push_back(nb);
    end
    @(negedge clk);
    expect_eq("out_valid", 128'(bus.out_valid_o), 128'(q.size() > 0));
    expect_eq("in_ready", 128'(bus.in_ready_o), 128'(q.size() < 2));
    if (q.size() > 0) begin
      for (int j = 0; j < DW; j++)
        expect_eq($sformatf("uop_lane%0d", j), 128'(bus.out_uop_o[j]), 128'(q[0].uop[j]));
      expect_eq("out_pc", 128'(bus.out_pc_o), 128'(q[0].pc));
      expect_eq("out_illegal", 128'(bus.out_illegal_o), 128'(q[0].ill));
    end
`ifdef RISCV_DECODE_STATS_EN
    expect_eq("stat_uops", 128'(stat_uops), 128'(m_uops));
    expect_eq("stat_illegal", 128'(stat_illegal), 128'(m_ill));
`endif
  endtask

  task automatic drive(input logic v, input logic [32*DW-1:0] instr, input logic [DW-1:0] mask,
                       input logic [XL-1:0] pc, input logic rdy);
    bus.in_valid_i  = v;
    bus.in_instr_i  = instr;
    bus.in_mask_i   = mask;
    bus.in_pc_i     = pc;
    bus.out_ready_i = rdy;
  endtask

  task automatic check_reset_payload();
    for (int j = 0; j < DW; j++)
      expect_eq($sformatf("rst_uop%0d", j), 128'(bus.out_uop_o[j]), 128'd0);
    expect_eq("rst_pc", 128'(bus.out_pc_o), 128'd0);
    expect_eq("rst_illegal", 128'(bus.out_illegal_o), 128'd0);
  endtask

  initial begin
    op_tab = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    m_uops = 0;
    m_ill  = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    cycle();
    cycle();
    check_reset_payload();
    rst = 1'b0;

    // addi x1,x0,5 in lane 0
    drive(1'b1, {32'h0000_0013, 32'h0050_0093}, 2'b01, 32'h0, 1'b1);
    cycle();
    expect_eq("addi_rd", 128'(bus.out_uop_o[0].rd), 128'd1);
    expect_eq("addi_rs1", 128'(bus.out_uop_o[0].rs1), 128'd0);
    expect_eq("addi_imm", 128'(bus.out_uop_o[0].imm), 128'd5);
    expect_eq("addi_alu", 128'(bus.out_uop_o[0].alu_op), 128'(ALU_ADD));
    expect_eq("addi_wr", 128'(bus.out_uop_o[0].writes_rd), 128'd1);
    expect_eq("addi_rs2", 128'(bus.out_uop_o[0].uses_rs2), 128'd0);

    // sub x3,x1,x2 in lane 1, pc 0x100
    drive(1'b1, {32'h4020_81B3, 32'h0050_0093}, 2'b11, 32'h100, 1'b1);
    cycle();
    expect_eq("sub_alu", 128'(bus.out_uop_o[1].alu_op), 128'(ALU_SUB));
    expect_eq("sub_rs2", 128'(bus.out_uop_o[1].uses_rs2), 128'd1);
    expect_eq("sub_pc1", 128'(bus.out_pc_o[XL +: XL]), 128'h104);

    // beq x1,x2,-4
    drive(1'b1, {32'h0, 32'hFE20_8EE3}, 2'b01, 32'h200, 1'b1);
    cycle();
    expect_eq("beq_imm", 128'(bus.out_uop_o[0].imm), 128'hFFFF_FFFC);
    expect_eq("beq_br", 128'(bus.out_uop_o[0].is_branch), 128'd1);
    expect_eq("beq_wr", 128'(bus.out_uop_o[0].writes_rd), 128'd0);
    expect_eq("beq_cond", 128'(bus.out_uop_o[0].branch_cond), 128'd0);

    // illegal lane 0, addi lane 1
    drive(1'b1, {32'h0050_0093, 32'hFFFF_FFFF}, 2'b11, 32'h300, 1'b1);
    cycle();
    expect_eq("ill_flags", 128'(bus.out_illegal_o), 128'b01);
    expect_eq("ill_v0", 128'(bus.out_uop_o[0].valid), 128'd0);
    expect_eq("ill_v1", 128'(bus.out_uop_o[1].valid), 128'd1);

    // backpressure: empty, then 4 offered bundles with consumer stalled
    drive(1'b0, '0, '0, '0, 1'b1);
    cycle();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, {32'h0, {12'(k), 5'd0, 3'b000, 5'(k), 7'h13}}, 2'b01, 32'(k * 16), 1'b0);
      cycle();
      if (k == 2) expect_eq("bp_ready_low", 128'(bus.in_ready_o), 128'd0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, '0, '0, 1'b1);
      cycle();
    end

    // flush with both entries full and a bundle offered
    drive(1'b1, {32'h0050_0093, 32'h0050_0093}, 2'b11, 32'h40, 1'b0);
    cycle();
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    expect_eq("flush_valid", 128'(bus.out_valid_o), 128'd0);
    expect_eq("flush_ready", 128'(bus.in_ready_o), 128'd1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 3) != 0, {rand_instr(), rand_instr()}, 2'($urandom),
            ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom),
            $urandom_range(0, 4) >= 2);
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cycle();
      if (rst) check_reset_payload();
    end
    rst   = 1'b0;
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
- Parametrised N-wide RISC-V RV32I decode pipeline stage between fetch and issue/rename.
- Each cycle it accepts a fetch bundle of DECODE_WIDTH instructions under a valid/ready handshake and decodes every lane into a uop.
- Results are presented through a registered, 2-entry skid-buffered output, so the stage sustains full throughput under backpressure.
- Covers all opcodes in the uop package: LOAD, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL. Also provides flush and illegal-instruction flagging.

Parameters:
- DECODE_WIDTH, 2: instructions per bundle (1..4).
- XLEN, 32: PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all buffered and incoming bundles this cycle.
- in_valid_i  in  1  fetch bundle valid.
- in_ready_o  out  1  stage can accept a bundle.
- in_instr_i  in  32*DECODE_WIDTH  lane j = bits [32j+31:32j].
- in_mask_i  in  DECODE_WIDTH  per-lane instruction-present bits.
- in_pc_i  in  XLEN  PC of lane 0.
- out_valid_o  out  1  decoded bundle valid.
- out_ready_i  in  1  consumer accepts the bundle.
- out_uop_o  out  DECODE_WIDTH x uop_t  decoded lanes.
- out_pc_o  out  XLEN*DECODE_WIDTH  per-lane PC.
- out_illegal_o  out  DECODE_WIDTH  per-lane illegal flag.

Behaviour:
- Reset: out_valid_o=0, in_ready_o=1, out_uop_o=0, out_pc_o=0, out_illegal_o=0; both buffer entries invalid.
- Handshake:
  - Transfer occurs when valid&&ready.
  - out_valid_o is held stable, with payload stable, until out_ready_i.
  - Latency is 1 cycle from input accept to out_valid_o.
- Buffer:
  - A main register and a skid register.
  - in_ready_o = !skid_valid, registered with no combinational path from out_ready_i.
  - Input is accepted while main is full and not draining: bundle goes to skid, in_ready_o falls next cycle.
  - When main drains: skid moves to main.
  - Simultaneous accept and drain with skid empty: main is overwritten.
- Lane PC: pc_j = in_pc_i + 4*j, modulo 2^XLEN (wraps).
- Lane decode is combinational before the main/skid registers.
  - Masked-off lane: uop.valid=0, illegal=0.
  - Unknown opcode, or funct3/funct7 combination not in RV32I: uop.valid=0, opcode=OPCODE_INVALID, illegal=1. Other lanes are unaffected.
- alu_op = {funct7[5],funct3}, zero-extended.
  - For OP_IMM, funct7[5] is used only when funct3=101 and is forced 0 otherwise.
  - LOAD/STORE/AUIPC/JAL/JALR/LUI: ALU_ADD.
  - BRANCH: funct3 is carried in branch_cond; alu_op=ALU_SUB.
- Immediates are sign-extended per ISA format: I (LOAD, OP_IMM, JALR), S, B, U, J.
  - is_immediate=1 for all non-OP opcodes.
- uses_rs1=0 for LUI/AUIPC/JAL. uses_rs2=1 only for OP/STORE/BRANCH.
- writes_rd=0 for STORE/BRANCH, and whenever rd==0.
- Flush:
  - Next cycle both entries are invalid and out_valid_o=0.
  - A bundle presented on the flush cycle is dropped even if accepted.
  - Flush has priority over all other events.
- rst asserted mid-transfer: identical to the reset state next cycle.

Optional Feature:
- Macro: RISCV_DECODE_STATS_EN.
- When defined, adds outputs stat_uops_o[31:0] and stat_illegal_o[31:0].
  - stat_uops_o: saturating count of valid uops delivered on output transfers.
  - stat_illegal_o: saturating count of illegal lanes delivered.
  - Both cleared by rst, not by flush.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- riscv_uop_pkg additions:
  - uop_t fields is_load, is_store, is_branch, is_jump, branch_cond[2:0], mem_size[2:0] (funct3 for LOAD/STORE).
  - imm_fmt_t enum (I,S,B,U,J,NONE).
  - Constant DECODE_WIDTH_MAX=4.
- Sub-module riscv_decode_lane: combinational single-instruction decoder (instr -> uop_t, illegal), instantiated DECODE_WIDTH times.

Test Plan:
- addi x1,x0,5 (0x00500093), lane 0, out_ready_i=1 -> one cycle later: rd=1, rs1=0, imm=5, alu_op=ALU_ADD, writes_rd=1, uses_rs2=0.
- sub x3,x1,x2 (0x402081B3) in lane 1, in_pc_i=0x100 -> alu_op=ALU_SUB, uses_rs2=1, out_pc lane1=0x104.
- beq x1,x2,-4 (0xFE208EE3) -> imm=0xFFFFFFFC, is_branch=1, writes_rd=0, branch_cond=000.
- 0xFFFFFFFF in lane 0, valid addi in lane 1 -> out_illegal_o=01, lane0 uop.valid=0, lane1 decoded normally.
- Continuous input with out_ready_i low for 3 cycles -> in_ready_o low after second accept; no bundle lost or duplicated; order preserved after release.
- flush_i with both entries full and in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1; stat counters (when RISCV_DECODE_STATS_EN is defined) unchanged.
